pattern_game_fsm: RTL and testbench
===================================

PATTERN_GAME_FSM -- requirements
Module: pattern_game_fsm

Interface
REQ-001 SHALL have parameter CLKS_PER_STEP, default 25000000: clocks per LED on-phase and per off-phase.
REQ-002 SHALL have parameter NUM_BTN, default 4: button/LED channel count, power of 2, 2..8.
REQ-003 SHALL have parameter GAME_LIMIT, default 8: sequence length needed to win, 2..16.
REQ-004 SHALL have parameter TIMEOUT_CLKS, default 125000000: player idle limit, used only under PATTERN_GAME_TIMEOUT_EN.
REQ-005 SHALL have port i_Clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port i_Rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port i_Start, input, 1: single-cycle start/restart pulse.
REQ-008 SHALL have port i_Btn, input, NUM_BTN: debounced buttons, 1 = pressed.
REQ-009 SHALL have port o_LED, output, NUM_BTN: LED drive, 1 = on.
REQ-010 SHALL have port o_Score, output, $clog2(GAME_LIMIT+1): completed rounds.
REQ-011 SHALL have ports o_Win and o_Fail, output, 1 each: high while in WIN or FAIL.

Function
REQ-012 SHALL implement states IDLE, LOAD, SHOW_ON, SHOW_OFF, WAIT_IN, INCR, WIN, FAIL.
REQ-013 SHALL go from any state to LOAD on the cycle after i_Start=1 (not in reset), clearing o_Score, index and step counter.
REQ-014 LOAD SHALL capture one $clog2(NUM_BTN)-bit LFSR slice per cycle into pattern[0..GAME_LIMIT-1], taking GAME_LIMIT cycles, then enter SHOW_ON with index 0.
REQ-015 SHOW_ON SHALL last exactly CLKS_PER_STEP cycles with o_LED one-hot at pattern[index], then enter SHOW_OFF.
REQ-016 SHOW_OFF SHALL last exactly CLKS_PER_STEP cycles with o_LED=0; then if index==o_Score enter WAIT_IN with index 0, else index+1 and SHOW_ON.
REQ-017 WAIT_IN SHALL mirror i_Btn onto o_LED; a button event is a 1->0 transition of any i_Btn bit vs. its 1-cycle-registered copy.
REQ-018 On simultaneous releases the lowest-index released button SHALL be the event; others are discarded.
REQ-019 Event matching pattern[index]: if index==o_Score enter INCR, else index+1 and stay in WAIT_IN; mismatch SHALL enter FAIL.
REQ-020 INCR SHALL last one cycle, set o_Score+1, enter WIN if new score==GAME_LIMIT, else SHOW_ON with index 0.
REQ-021 WIN and FAIL SHALL toggle all o_LED bits together every CLKS_PER_STEP cycles, starting on, and hold until i_Start or reset.
REQ-022 IDLE SHALL drive o_LED=0 and wait for i_Start.
REQ-023 Button events outside WAIT_IN SHALL be ignored and not queued.
REQ-024 The LFSR SHALL free-run every cycle, including in IDLE, so pattern depends on start time.

Reset
REQ-025 i_Rst SHALL force IDLE, o_Score=0, o_LED=0, o_Win=0, o_Fail=0, index=0, counters=0, edge registers=0, regardless of state or i_Start.
REQ-026 The LFSR SHALL reset to a fixed non-zero seed 22'h000001.
REQ-027 Pattern storage SHALL not require reset.

Configuration
REQ-028 With PATTERN_GAME_TIMEOUT_EN defined, WAIT_IN SHALL enter FAIL after TIMEOUT_CLKS consecutive cycles without a button event; the counter restarts on every event and on WAIT_IN entry.
REQ-029 Without PATTERN_GAME_TIMEOUT_EN, WAIT_IN SHALL wait indefinitely and no timeout counter SHALL be synthesised.

Structure
REQ-030 A shared package SHALL hold the state encoding type and the LFSR seed constant.
REQ-031 The 22-bit LFSR SHALL be a sub-module, lfsr_22, exposing a 22-bit data output.
REQ-032 Step timing SHALL use one shared counter, cleared on every state change.

Verification
REQ-033 Reset mid-SHOW_ON, CLKS_PER_STEP=4 -> next cycle IDLE, o_LED=0, o_Score=0.
REQ-034 GAME_LIMIT=2, NUM_BTN=4, CLKS_PER_STEP=4, correct releases each round -> o_Score 1 then 2, o_Win=1, LEDs toggle every 4 cycles.
REQ-035 Round 1, release wrong button -> FAIL next cycle, o_Fail=1, o_Score unchanged at 0.
REQ-036 Buttons 1 and 3 released same cycle, pattern[0]=1 -> accepted as 1, score increments.
REQ-037 With macro, TIMEOUT_CLKS=10, no input in WAIT_IN -> FAIL exactly 10 cycles after entry; without macro, still WAIT_IN after 1000 cycles.
REQ-038 i_Start during SHOW_OFF of round 3 -> LOAD next cycle, o_Score=0, SHOW_ON after GAME_LIMIT cycles.

Source files
------------

// File: rtl/pattern_game_fsm_pkg.sv
// Pattern memory game: shared definitions.
//   state_t      - FSM state type used by pattern_game_fsm
//   LFSR_SEED    - non-zero reset value of the 22-bit pattern LFSR
//   lfsr22_next  - one step of the x^22 + x^21 + 1 Fibonacci LFSR
package pattern_game_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_WAIT_IN,
    ST_INCR,
    ST_WIN,
    ST_FAIL
  } state_t;

  localparam logic [21:0] LFSR_SEED = 22'h000001;

  function automatic logic [21:0] lfsr22_next(input logic [21:0] v);
    return {v[20:0], v[21] ^ v[20]};
  endfunction

endpackage

// File: rtl/lfsr_22.sv
// Free-running 22-bit maximal-length LFSR (x^22 + x^21 + 1).
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, loads LFSR_SEED
//   data - current LFSR state, advances every cycle out of reset
module lfsr_22
  import pattern_game_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [21:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= LFSR_SEED;
    end else begin
      data <= lfsr22_next(data);
    end
  end

endmodule

// File: rtl/pattern_game_fsm.sv
// Pattern memory game ("Simon"): shows a growing LED sequence, then checks
// the player's button releases against it.
//   i_Clk   - clock, rising edge
//   i_Rst   - synchronous active-high reset
//   i_Start - single-cycle start/restart pulse, honoured in any state
//   i_Btn   - debounced buttons, 1 = pressed; a release (1->0) is an event
//   o_LED   - LED drive, 1 = on
//   o_Score - completed rounds
//   o_Win   - high while in WIN
//   o_Fail  - high while in FAIL
// Build option: define PATTERN_GAME_TIMEOUT_EN to fail after TIMEOUT_CLKS
// idle cycles in WAIT_IN; otherwise WAIT_IN waits indefinitely.
module pattern_game_fsm
  import pattern_game_fsm_pkg::*;
#(
  parameter int unsigned CLKS_PER_STEP = 25000000,
  parameter int unsigned NUM_BTN       = 4,
  parameter int unsigned GAME_LIMIT    = 8,
  parameter int unsigned TIMEOUT_CLKS  = 125000000
) (
  input  logic                               i_Clk,
  input  logic                               i_Rst,
  input  logic                               i_Start,
  input  logic [NUM_BTN-1:0]                 i_Btn,
  output logic [NUM_BTN-1:0]                 o_LED,
  output logic [$clog2(GAME_LIMIT+1)-1:0]    o_Score,
  output logic                               o_Win,
  output logic                               o_Fail
);

  localparam int unsigned SEL_W   = $clog2(NUM_BTN);
  localparam int unsigned IDX_W   = $clog2(GAME_LIMIT);
  localparam int unsigned SCORE_W = $clog2(GAME_LIMIT + 1);
  localparam int unsigned CNT_W   = (CLKS_PER_STEP > 1) ? $clog2(CLKS_PER_STEP) : 1;

  localparam logic [CNT_W-1:0]   STEP_LAST = CNT_W'(CLKS_PER_STEP - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(GAME_LIMIT - 1);
  localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(GAME_LIMIT);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] score_nxt;
  logic [NUM_BTN-1:0] led;
  logic               win;
  logic               fail;
  logic [NUM_BTN-1:0] btn_q;
  logic [NUM_BTN-1:0] released;
  logic               evt;
  logic               evt_found;
  logic [SEL_W-1:0]   evt_btn;
  logic [21:0]        lfsr_data;
  logic               unused_lfsr_hi;
  logic [SEL_W-1:0]   pattern [GAME_LIMIT];

  function automatic logic [NUM_BTN-1:0] onehot(input logic [SEL_W-1:0] sel);
    return {{(NUM_BTN-1){1'b0}}, 1'b1} << sel;
  endfunction

  lfsr_22 u_lfsr (
    .clk  (i_Clk),
    .rst  (i_Rst),
    .data (lfsr_data)
  );

  assign unused_lfsr_hi = ^lfsr_data[21:SEL_W];

  assign idx_nxt   = idx + 1'b1;
  assign score_nxt = score + 1'b1;
  assign released  = btn_q & ~i_Btn;
  assign evt       = |released;

  // Lowest-index release wins; the rest of a simultaneous release is dropped.
  always_comb begin
    evt_btn   = '0;
    evt_found = 1'b0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (released[i] && !evt_found) begin
        evt_btn   = SEL_W'(i);
        evt_found = 1'b1;
      end
    end
  end

  // Pattern storage carries no reset; it is always rewritten during LOAD.
  always_ff @(posedge i_Clk) begin
    if (state == ST_LOAD) begin
      pattern[idx] <= lfsr_data[SEL_W-1:0];
    end
  end

`ifdef PATTERN_GAME_TIMEOUT_EN
  localparam int unsigned        TO_W    = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

  logic [TO_W-1:0] to_cnt;
  logic            timed_out;

  // Counts consecutive idle WAIT_IN cycles; zero on entry and after each event.
  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Start || state != ST_WAIT_IN || evt) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timed_out = (to_cnt == TO_LAST);
`else
  localparam int unsigned UNUSED_TIMEOUT_CLKS = TIMEOUT_CLKS;
`endif

  // LED is registered, so every transition loads the value the next state
  // must show on its first cycle.
  always_ff @(posedge i_Clk) begin
    btn_q <= i_Btn;
    if (i_Rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      cnt   <= '0;
      score <= '0;
      led   <= '0;
      win   <= 1'b0;
      fail  <= 1'b0;
      btn_q <= '0;
    end else if (i_Start) begin
      state <= ST_LOAD;
      idx   <= '0;
      cnt   <= '0;
      score <= '0;
      led   <= '0;
      win   <= 1'b0;
      fail  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          led <= '0;
        end
        ST_LOAD: begin
          if (idx == IDX_LAST) begin
            state <= ST_SHOW_ON;
            idx   <= '0;
            cnt   <= '0;
            led   <= onehot(pattern[0]);
          end else begin
            idx <= idx_nxt;
          end
        end
        ST_SHOW_ON: begin
          if (cnt == STEP_LAST) begin
            state <= ST_SHOW_OFF;
            cnt   <= '0;
            led   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SHOW_OFF: begin
          if (cnt == STEP_LAST) begin
            cnt <= '0;
            if (SCORE_W'(idx) == score) begin
              state <= ST_WAIT_IN;
              idx   <= '0;
              led   <= i_Btn;
            end else begin
              state <= ST_SHOW_ON;
              idx   <= idx_nxt;
              led   <= onehot(pattern[idx_nxt]);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_IN: begin
          led <= i_Btn;
          if (evt) begin
            if (evt_btn == pattern[idx]) begin
              if (SCORE_W'(idx) == score) begin
                state <= ST_INCR;
                idx   <= '0;
                cnt   <= '0;
                led   <= '0;
              end else begin
                idx <= idx_nxt;
              end
            end else begin
              state <= ST_FAIL;
              cnt   <= '0;
              fail  <= 1'b1;
              led   <= '1;
            end
          end
`ifdef PATTERN_GAME_TIMEOUT_EN
          else if (timed_out) begin
            state <= ST_FAIL;
            cnt   <= '0;
            fail  <= 1'b1;
            led   <= '1;
          end
`endif
        end
        ST_INCR: begin
          score <= score_nxt;
          cnt   <= '0;
          if (score_nxt == SCORE_WIN) begin
            state <= ST_WIN;
            win   <= 1'b1;
            led   <= '1;
          end else begin
            state <= ST_SHOW_ON;
            led   <= onehot(pattern[0]);
          end
        end
        ST_WIN, ST_FAIL: begin
          if (cnt == STEP_LAST) begin
            cnt <= '0;
            led <= ~led;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_LED   = led;
  assign o_Score = score;
  assign o_Win   = win;
  assign o_Fail  = fail;

endmodule

// File: tb/tb_pattern_game_fsm.sv
// Self-checking bench for pattern_game_fsm (CLKS_PER_STEP=4, NUM_BTN=4,
// GAME_LIMIT=3, TIMEOUT_CLKS=10). The expected pattern comes from the
// documented generator: a 22-bit LFSR (x^22+x^21+1, seed 1) stepping every
// clock out of reset, with pattern[k] = low 2 bits of its value in the k-th
// cycle after the start pulse. Game behaviour is modelled per round/press.
module tb_pattern_game_fsm;

  localparam int unsigned CPS = 4;
  localparam int unsigned NB  = 4;
  localparam int unsigned GL  = 3;
  localparam int unsigned TO  = 10;
  localparam int unsigned SCW = $clog2(GL + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [NB-1:0]  btn = '0;
  logic [NB-1:0]  led;
  logic [SCW-1:0] score;
  logic           win;
  logic           fail;

  pattern_game_fsm #(
    .CLKS_PER_STEP (CPS),
    .NUM_BTN       (NB),
    .GAME_LIMIT    (GL),
    .TIMEOUT_CLKS  (TO)
  ) dut (
    .i_Clk   (clk),
    .i_Rst   (rst),
    .i_Start (start),
    .i_Btn   (btn),
    .o_LED   (led),
    .o_Score (score),
    .o_Win   (win),
    .o_Fail  (fail)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [21:0] sh = 22'h000001;
  logic [21:0] hist[$];
  int          start_at = 0;

  typedef struct {
    logic           r;
    logic           s;
    logic [NB-1:0]  b;
    logic [NB-1:0]  led;
    logic [SCW-1:0] score;
    logic           win;
    logic           fail;
  } vec_t;

  function automatic logic [21:0] lfsr_step(input logic [21:0] v);
    return {v[20:0], v[21] ^ v[20]};
  endfunction

  function automatic logic [1:0] pat(input int k);
    logic [21:0] v;
    v = hist[start_at + k];
    return v[1:0];
  endfunction

  function automatic logic [NB-1:0] oh(input logic [1:0] p);
    logic [NB-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  function automatic logic [1:0] lowest(input logic [NB-1:0] m);
    for (int i = 0; i < NB; i++) if (m[i]) return 2'(i);
    return 2'd0;
  endfunction

  // Random release mask; with probability pct its lowest bit is the target.
  function automatic logic [NB-1:0] pick(input logic [1:0] t, input int pct);
    logic [NB-1:0] one, r;
    one = oh(t);
    r = NB'($urandom);
    if ($urandom_range(0, 99) < pct) return one | (r & ~(one | (one - 1'b1)));
    return NB'($urandom_range(1, (1 << NB) - 1));
  endfunction

  // One clock; also advances the generator model and notes start pulses.
  task automatic tick();
    logic took_start;
    logic was_rst;
    took_start = start && !rst;
    was_rst = rst;
    @(posedge clk);
    #1;
    sh = was_rst ? 22'h000001 : lfsr_step(sh);
    hist.push_back(sh);
    if (took_start) start_at = hist.size() - 1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string name, input logic [NB-1:0] el,
                            input logic [SCW-1:0] es, input logic ew, input logic ef);
    check({name, ".led"},   32'(led),   32'(el));
    check({name, ".score"}, 32'(score), 32'(es));
    check({name, ".win"},   32'(win),   32'(ew));
    check({name, ".fail"},  32'(fail),  32'(ef));
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_outs("load", '0, '0, 1'b0, 1'b0);
    repeat (GL - 1) begin
      tick();
      check_outs("load", '0, '0, 1'b0, 1'b0);
    end
    tick();
  endtask

  // From SHOW_ON cycle 0 of round s to WAIT_IN cycle 0; noise = stray presses.
  task automatic show_round(input int s, input bit noise);
    for (int i = 0; i <= s; i++) begin
      for (int c = 0; c < CPS; c++) begin
        check_outs("show_on", oh(pat(i)), SCW'(s), 1'b0, 1'b0);
        if (noise && i == 0 && c == 0) btn = NB'($urandom_range(1, (1 << NB) - 1));
        if (noise && i == 0 && c == 1) btn = '0;
        tick();
      end
      for (int c = 0; c < CPS; c++) begin
        check_outs("show_off", '0, SCW'(s), 1'b0, 1'b0);
        tick();
      end
    end
  endtask

  // Plays rounds s0..s_stop-1. result: 0 win, 1 fail, 2 stopped at SHOW_ON.
  task automatic play_rounds(input int s0, input int s_stop, input bit noise,
                             input int pct, output int result, output int fscore);
    result = 2;
    fscore = s_stop;
    for (int s = s0; s < s_stop; s++) begin
      show_round(s, noise);
      for (int i = 0; i <= s; i++) begin
        logic [NB-1:0] m;
        m = pick(pat(i), pct);
        repeat ($urandom_range(0, 3)) begin
          check_outs("wait", '0, SCW'(s), 1'b0, 1'b0);
          tick();
        end
        btn = m;
        tick();
        check("mirror", 32'(led), 32'(m));
        btn = '0;
        tick();
        if (lowest(m) != pat(i)) begin
          check_outs("wrong_press", '1, SCW'(s), 1'b0, 1'b1);
          result = 1;
          fscore = s;
          return;
        end
        if (i < s) begin
          check_outs("next_press", '0, SCW'(s), 1'b0, 1'b0);
        end else begin
          check_outs("incr", '0, SCW'(s), 1'b0, 1'b0);
          tick();
          if (s + 1 == GL) begin
            check_outs("win_entry", '1, SCW'(s + 1), 1'b1, 1'b0);
            result = 0;
            fscore = s + 1;
            return;
          end
          check_outs("next_round", oh(pat(0)), SCW'(s + 1), 1'b0, 1'b0);
        end
      end
    end
  endtask

  task automatic end_check(input logic w, input logic [SCW-1:0] sc);
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < CPS; c++) begin
        check_outs(w ? "win_blink" : "lose_blink", (p % 2 == 0) ? {NB{1'b1}} : {NB{1'b0}},
                   sc, w, !w);
        tick();
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    int   res, fsc;
    bit   found;

    vt[0] = '{1'b1, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b1, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b0, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0};
    vt[3] = '{1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0};
    vt[4] = '{1'b0, 1'b1, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0};
    vt[5] = '{1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0};
    vt[6] = '{1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0};

    // Reset, idle and LOAD cycles.
    for (int i = 0; i < 7; i++) begin
      rst = vt[i].r;
      start = vt[i].s;
      btn = vt[i].b;
      tick();
      check_outs($sformatf("vec%0d", i), vt[i].led, vt[i].score, vt[i].win, vt[i].fail);
    end
    start = 1'b0;
    tick();

    // First full game with correct play and stray presses during SHOW_ON.
    play_rounds(0, GL, 1'b1, 100, res, fsc);
    check("first_game_won", 32'(res), 32'd0);
    end_check(1'b1, SCW'(GL));

    // Reset in the middle of SHOW_ON.
    start_game();
    play_rounds(0, 1, 1'b0, 100, res, fsc);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_outs("reset_mid_show", '0, '0, 1'b0, 1'b0);
    tick();
    check_outs("idle_after_reset", '0, '0, 1'b0, 1'b0);

    // Wrong button in round 1.
    start_game();
    show_round(0, 1'b0);
    btn = oh(pat(0) + 2'd1);
    tick();
    btn = '0;
    tick();
    check_outs("wrong_round1", '1, '0, 1'b0, 1'b1);
    end_check(1'b0, '0);

    // Buttons 1 and 3 released together with pattern[0] == 1.
    found = 1'b0;
    for (int n = 0; n < 64 && !found; n++) begin
      if (lfsr_step(sh) % 4 == 1) found = 1'b1;
      else tick();
    end
    check("seek_pattern1", 32'(found), 32'd1);
    start_game();
    show_round(0, 1'b0);
    btn = 4'b1010;
    tick();
    btn = '0;
    tick();
    check_outs("dual_release", '0, '0, 1'b0, 1'b0);
    tick();
    check_outs("dual_release_score", oh(pat(0)), 2'd1, 1'b0, 1'b0);

    // Restart during SHOW_OFF of round 3.
    start_game();
    play_rounds(0, 2, 1'b0, 100, res, fsc);
    repeat (CPS) begin
      check_outs("r3_show_on", oh(pat(0)), 2'd2, 1'b0, 1'b0);
      tick();
    end
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_outs("restart_load", '0, '0, 1'b0, 1'b0);
    repeat (GL - 1) begin
      tick();
      check_outs("restart_load", '0, '0, 1'b0, 1'b0);
    end
    tick();
    check_outs("restart_show", oh(pat(0)), '0, 1'b0, 1'b0);
    play_rounds(0, GL, 1'b0, 100, res, fsc);
    check("restart_game_won", 32'(res), 32'd0);
    end_check(1'b1, SCW'(GL));

    // Idle player in WAIT_IN.
    start_game();
    show_round(0, 1'b0);
`ifdef PATTERN_GAME_TIMEOUT_EN
    repeat (TO - 1) begin
      check_outs("timeout_wait", '0, '0, 1'b0, 1'b0);
      tick();
    end
    check_outs("timeout_last", '0, '0, 1'b0, 1'b0);
    tick();
    check_outs("timeout_fail", '1, '0, 1'b0, 1'b1);
`else
    repeat (1000) tick();
    check_outs("no_timeout", '0, '0, 1'b0, 1'b0);
`endif

    // Randomized games against the round model.
    for (int g = 0; g < 25; g++) begin
      repeat ($urandom_range(0, 7)) tick();
      start_game();
      play_rounds(0, GL, 1'($urandom_range(0, 1)), 80, res, fsc);
      end_check(res == 0, SCW'(fsc));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
